// File: rtl/pagerank_gather_scheduler.sv
// pagerank_gather_scheduler: iterates the gather accumulator and round-robin
// arbitrates scatter beats onto its single update port.
module pagerank_gather_scheduler #(
    parameter int NUM_THREADS    = 4,
    parameter int NODES_IN_GRAPH = 32,
    parameter int MAX_ITERATIONS = 16
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [NUM_THREADS-1:0]                 req_valid,
    input  logic [NUM_THREADS*64-1:0]              req_page_rank,
    input  logic [NUM_THREADS*32-1:0]              req_dest_id,
    output logic [NUM_THREADS-1:0]                 req_ready,
    input  logic [NUM_THREADS-1:0]                 thread_scatter_done,
    input  logic                                   gather_operation_complete,
    output logic                                   pagerank_enable,
    output logic                                   nextIteration,
    output logic                                   pagerank_ready,
    output logic [63:0]                            page_rank_scatter,
    output logic [31:0]                            dest_id,
    output logic                                   scatter_operation_complete,
    output logic [$clog2(MAX_ITERATIONS+1)-1:0]    iteration_count,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   dest_error
);
    localparam int PW = NUM_THREADS > 1 ? $clog2(NUM_THREADS) : 1;
    localparam int CW = $clog2(MAX_ITERATIONS + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_GATHER, S_FINISH, S_ADVANCE, S_DONE} state_e;

    state_e                 state_q, state_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [NUM_THREADS-1:0] mask_q, mask_d;
    logic [CW-1:0]          iter_q, iter_d;
    logic                   err_q, err_d;
    logic                   prv_q, prv_d;
    logic [63:0]            prs_q, prs_d;
    logic [31:0]            dst_q, dst_d;

    logic [PW-1:0]          sel, idx;
    logic                   found, accept, in_range;
    logic [63:0]            sel_prs;
    logic [31:0]            sel_dst;

    // Search starts one past the last granted thread so every requester gets a turn.
    always_comb begin
        sel   = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_THREADS; k++) begin
            idx = PW'((int'(ptr_q) + k) % NUM_THREADS);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign accept    = (state_q == S_GATHER) && found;
    assign req_ready = {{(NUM_THREADS-1){1'b0}}, accept} << sel;
    assign sel_prs   = req_page_rank[64*sel +: 64];
    assign sel_dst   = req_dest_id[32*sel +: 32];
    assign in_range  = sel_dst < 32'(NODES_IN_GRAPH);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        mask_d  = mask_q;
        iter_d  = iter_q;
        err_d   = err_q;
        prv_d   = 1'b0;
        prs_d   = prs_q;
        dst_d   = dst_q;
        case (state_q)
            S_IDLE: if (start) begin
                iter_d  = '0;
                err_d   = 1'b0;
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                mask_d  = '0;
                state_d = S_GATHER;
            end
            S_GATHER: begin
                mask_d = mask_q | thread_scatter_done;
                if (accept) begin
                    ptr_d = sel;
                    if (in_range) begin
                        prv_d = 1'b1;
                        prs_d = sel_prs;
                        dst_d = sel_dst;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (&mask_d && !(|req_valid)) state_d = S_FINISH;
            end
            S_FINISH: if (gather_operation_complete) state_d = S_ADVANCE;
            S_ADVANCE: begin
                iter_d  = iter_q + 1'b1;
                state_d = (iter_d == CW'(MAX_ITERATIONS)) ? S_DONE : S_CLEAR;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            mask_q  <= '0;
            iter_q  <= '0;
            err_q   <= 1'b0;
            prv_q   <= 1'b0;
            prs_q   <= '0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            mask_q  <= mask_d;
            iter_q  <= iter_d;
            err_q   <= err_d;
            prv_q   <= prv_d;
            prs_q   <= prs_d;
            dst_q   <= dst_d;
        end
    end

    assign busy                       = state_q != S_IDLE;
    assign pagerank_enable            = busy;
    assign nextIteration              = state_q == S_CLEAR;
    assign scatter_operation_complete = state_q == S_FINISH;
    assign done                       = state_q == S_DONE;
    assign pagerank_ready             = prv_q;
    assign page_rank_scatter          = prs_q;
    assign dest_id                    = dst_q;
    assign iteration_count            = iter_q;
    assign dest_error                 = err_q;
endmodule

// File: tb/tb_pagerank_gather_scheduler.sv
// tb_pagerank_gather_scheduler: directed vector table plus hand-written reset and
// timeout sequences, with a behavioural accumulator fed by the scheduler outputs.
module tb_pagerank_gather_scheduler;
    localparam int NT = 4;

    logic           clock = 1'b0;
    logic           reset, start, gather_operation_complete;
    logic [NT-1:0]  req_valid, req_ready, thread_scatter_done;
    logic [NT*64-1:0] req_page_rank;
    logic [NT*32-1:0] req_dest_id;
    logic           pagerank_enable, nextIteration, pagerank_ready;
    logic [63:0]    page_rank_scatter;
    logic [31:0]    dest_id;
    logic           scatter_operation_complete, busy, done, dest_error;
    logic [1:0]     iteration_count;

    int checks = 0;
    int errors = 0;
    logic [63:0] acc [32];

    pagerank_gather_scheduler #(.NUM_THREADS(NT), .NODES_IN_GRAPH(32), .MAX_ITERATIONS(3)) dut (
        .clock(clock), .reset(reset), .start(start),
        .req_valid(req_valid), .req_page_rank(req_page_rank), .req_dest_id(req_dest_id),
        .req_ready(req_ready), .thread_scatter_done(thread_scatter_done),
        .gather_operation_complete(gather_operation_complete),
        .pagerank_enable(pagerank_enable), .nextIteration(nextIteration),
        .pagerank_ready(pagerank_ready), .page_rank_scatter(page_rank_scatter),
        .dest_id(dest_id), .scatter_operation_complete(scatter_operation_complete),
        .iteration_count(iteration_count), .busy(busy), .done(done), .dest_error(dest_error)
    );

    always #5 clock = ~clock;

    initial for (int i = 0; i < 32; i++) acc[i] = '0;

    always @(posedge clock) begin
        if (nextIteration) begin
            for (int i = 0; i < 32; i++) acc[i] <= '0;
        end else if (pagerank_ready) begin
            acc[dest_id[4:0]] <= acc[dest_id[4:0]] + page_rank_scatter;
        end
    end

    typedef struct packed {
        logic        start;
        logic [3:0]  v;
        logic [3:0]  d;
        logic [31:0] dest;
        logic [63:0] data;
        logic        gc;
        logic [3:0]  e_rdy;
        logic        e_prv;
        logic [63:0] e_prs;
        logic [31:0] e_dst;
        logic        e_soc;
        logic        e_nxt;
        logic        e_busy;
        logic        e_done;
        logic [1:0]  e_it;
        logic        e_err;
        logic        ca;
        logic [4:0]  aa;
        logic [63:0] av;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        start = r.start;
        req_valid = r.v;
        thread_scatter_done = r.d;
        gather_operation_complete = r.gc;
        for (int t = 0; t < NT; t++) begin
            req_page_rank[t*64 +: 64] = r.data + 64'(t);
            req_dest_id[t*32 +: 32] = r.dest;
        end
    endtask

    task automatic idle_inputs();
        start = 1'b0;
        req_valid = '0;
        thread_scatter_done = '0;
        gather_operation_complete = 1'b0;
        req_page_rank = '0;
        req_dest_id = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // fields: start v d dest data gc | rdy prv prs dst soc nxt busy done it err | ca aa av
        tv.push_back(vec_t'{1,'b0000,'b0000,0,0,0,       'b0000,0,0,0,       0,0,0,0,0,0, 0,0,0});
        tv.push_back(vec_t'{0,'b0000,'b0000,0,0,0,       'b0000,0,0,0,       0,1,1,0,0,0, 0,0,0});
        tv.push_back(vec_t'{0,'b0001,'b0000,3,'h10,0,    'b0001,0,0,0,       0,0,1,0,0,0, 0,0,0});
        tv.push_back(vec_t'{0,'b0001,'b1111,3,'h20,0,    'b0001,1,'h10,3,    0,0,1,0,0,0, 0,0,0});
        tv.push_back(vec_t'{0,'b0000,'b0000,0,0,0,       'b0000,1,'h20,3,    0,0,1,0,0,0, 0,0,0});
        tv.push_back(vec_t'{0,'b0000,'b0000,0,0,0,       'b0000,0,0,0,       1,0,1,0,0,0, 1,3,'h30});
        tv.push_back(vec_t'{0,'b0000,'b0000,0,0,1,       'b0000,0,0,0,       1,0,1,0,0,0, 0,0,0});
        tv.push_back(vec_t'{0,'b0000,'b0000,0,0,0,       'b0000,0,0,0,       0,0,1,0,0,0, 0,0,0});
        tv.push_back(vec_t'{0,'b0000,'b0000,0,0,0,       'b0000,0,0,0,       0,1,1,0,1,0, 0,0,0});
        tv.push_back(vec_t'{0,'b1111,'b0000,1,'h100,0,   'b0010,0,0,0,       0,0,1,0,1,0, 0,0,0});
        tv.push_back(vec_t'{0,'b1111,'b0000,1,'h100,0,   'b0100,1,'h101,1,   0,0,1,0,1,0, 0,0,0});
        tv.push_back(vec_t'{0,'b1111,'b0000,1,'h100,0,   'b1000,1,'h102,1,   0,0,1,0,1,0, 0,0,0});
        tv.push_back(vec_t'{0,'b1111,'b0000,1,'h100,0,   'b0001,1,'h103,1,   0,0,1,0,1,0, 0,0,0});
        tv.push_back(vec_t'{0,'b1111,'b0000,1,'h100,0,   'b0010,1,'h100,1,   0,0,1,0,1,0, 0,0,0});
        tv.push_back(vec_t'{0,'b1111,'b0000,1,'h100,0,   'b0100,1,'h101,1,   0,0,1,0,1,0, 0,0,0});
        tv.push_back(vec_t'{0,'b1111,'b0000,1,'h100,0,   'b1000,1,'h102,1,   0,0,1,0,1,0, 0,0,0});
        tv.push_back(vec_t'{0,'b1111,'b0011,1,'h100,0,   'b0001,1,'h103,1,   0,0,1,0,1,0, 0,0,0});
        tv.push_back(vec_t'{0,'b0100,'b0100,40,'h200,0,  'b0100,1,'h100,1,   0,0,1,0,1,0, 0,0,0});
        tv.push_back(vec_t'{0,'b1000,'b0000,2,'h300,0,   'b1000,0,0,0,       0,0,1,0,1,1, 0,0,0});
        tv.push_back(vec_t'{0,'b1000,'b0000,2,'h310,0,   'b1000,1,'h303,2,   0,0,1,0,1,1, 0,0,0});
        tv.push_back(vec_t'{0,'b0000,'b0000,0,0,0,       'b0000,1,'h313,2,   0,0,1,0,1,1, 0,0,0});
        tv.push_back(vec_t'{0,'b0000,'b0000,0,0,0,       'b0000,0,0,0,       0,0,1,0,1,1, 0,0,0});
        tv.push_back(vec_t'{0,'b1000,'b1000,2,'h320,0,   'b1000,0,0,0,       0,0,1,0,1,1, 0,0,0});
        tv.push_back(vec_t'{0,'b0000,'b0000,0,0,0,       'b0000,1,'h323,2,   0,0,1,0,1,1, 0,0,0});
        tv.push_back(vec_t'{0,'b0000,'b0000,0,0,1,       'b0000,0,0,0,       1,0,1,0,1,1, 1,2,'h939});
        tv.push_back(vec_t'{0,'b0000,'b0000,0,0,0,       'b0000,0,0,0,       0,0,1,0,1,1, 0,0,0});
        tv.push_back(vec_t'{0,'b0000,'b0000,0,0,0,       'b0000,0,0,0,       0,1,1,0,2,1, 0,0,0});
        tv.push_back(vec_t'{0,'b0000,'b1111,0,0,0,       'b0000,0,0,0,       0,0,1,0,2,1, 0,0,0});
        tv.push_back(vec_t'{1,'b0000,'b0000,0,0,1,       'b0000,0,0,0,       1,0,1,0,2,1, 0,0,0});
        tv.push_back(vec_t'{0,'b0000,'b0000,0,0,0,       'b0000,0,0,0,       0,0,1,0,2,1, 0,0,0});
        tv.push_back(vec_t'{0,'b0000,'b0000,0,0,0,       'b0000,0,0,0,       0,0,1,1,3,1, 0,0,0});
        tv.push_back(vec_t'{0,'b0000,'b0000,0,0,0,       'b0000,0,0,0,       0,0,0,0,3,1, 0,0,0});
        tv.push_back(vec_t'{1,'b0000,'b0000,0,0,0,       'b0000,0,0,0,       0,0,0,0,3,1, 0,0,0});
        for (int it = 0; it < 3; it++) begin
            if (it > 0)
                tv.push_back(vec_t'{0,'b0000,'b0000,0,0,0, 'b0000,0,0,0, 0,0,1,0,2'(it-1),0, 0,0,0});
            tv.push_back(vec_t'{0,'b0000,'b0000,0,0,0,     'b0000,0,0,0, 0,1,1,0,2'(it),0, 0,0,0});
            tv.push_back(vec_t'{0,'b0001,'b1111,0,5,0,     'b0001,0,0,0, 0,0,1,0,2'(it),0, 0,0,0});
            tv.push_back(vec_t'{0,'b0000,'b0000,0,0,0,     'b0000,1,5,0, 0,0,1,0,2'(it),0, 0,0,0});
            tv.push_back(vec_t'{0,'b0000,'b0000,0,0,1,     'b0000,0,0,0, 1,0,1,0,2'(it),0, 1,0,5});
        end
        tv.push_back(vec_t'{0,'b0000,'b0000,0,0,0,       'b0000,0,0,0,       0,0,1,0,2,0, 0,0,0});
        tv.push_back(vec_t'{0,'b0000,'b0000,0,0,0,       'b0000,0,0,0,       0,0,1,1,3,0, 0,0,0});
        tv.push_back(vec_t'{0,'b0000,'b0000,0,0,0,       'b0000,0,0,0,       0,0,0,0,3,0, 0,0,0});

        idle_inputs();
        reset = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        #1;
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset enable", 64'(pagerank_enable), 64'(0));
        chk("reset ready", 64'(pagerank_ready), 64'(0));
        chk("reset iter", 64'(iteration_count), 64'(0));
        chk("reset err", 64'(dest_error), 64'(0));

        foreach (tv[i]) begin
            @(negedge clock);
            drive(tv[i]);
            #1;
            chk($sformatf("row%0d req_ready", i), 64'(req_ready), 64'(tv[i].e_rdy));
            chk($sformatf("row%0d pagerank_ready", i), 64'(pagerank_ready), 64'(tv[i].e_prv));
            if (tv[i].e_prv) begin
                chk($sformatf("row%0d page_rank", i), page_rank_scatter, tv[i].e_prs);
                chk($sformatf("row%0d dest_id", i), 64'(dest_id), 64'(tv[i].e_dst));
            end
            chk($sformatf("row%0d scatter_complete", i), 64'(scatter_operation_complete), 64'(tv[i].e_soc));
            chk($sformatf("row%0d nextIteration", i), 64'(nextIteration), 64'(tv[i].e_nxt));
            chk($sformatf("row%0d busy", i), 64'(busy), 64'(tv[i].e_busy));
            chk($sformatf("row%0d enable", i), 64'(pagerank_enable), 64'(tv[i].e_busy));
            chk($sformatf("row%0d done", i), 64'(done), 64'(tv[i].e_done));
            chk($sformatf("row%0d iter", i), 64'(iteration_count), 64'(tv[i].e_it));
            chk($sformatf("row%0d dest_error", i), 64'(dest_error), 64'(tv[i].e_err));
            if (tv[i].ca) chk($sformatf("row%0d acc", i), acc[tv[i].aa], tv[i].av);
        end

        // Reset in the middle of GATHER with a beat pending and dest_error set.
        @(negedge clock);
        idle_inputs();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        req_valid = 4'b0100;
        for (int t = 0; t < NT; t++) req_dest_id[t*32 +: 32] = 32'd40;
        @(negedge clock);
        req_valid = 4'b1111;
        for (int t = 0; t < NT; t++) begin
            req_dest_id[t*32 +: 32] = 32'd7;
            req_page_rank[t*64 +: 64] = 64'h500 + 64'(t);
        end
        @(negedge clock);
        #1;
        chk("midrun pending beat", 64'(pagerank_ready), 64'(1));
        chk("midrun pending data", page_rank_scatter, 64'h503);
        chk("midrun err", 64'(dest_error), 64'(1));
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("post-reset busy", 64'(busy), 64'(0));
        chk("post-reset req_ready", 64'(req_ready), 64'(0));
        chk("post-reset pagerank_ready", 64'(pagerank_ready), 64'(0));
        chk("post-reset page_rank", page_rank_scatter, 64'(0));
        chk("post-reset dest_id", 64'(dest_id), 64'(0));
        chk("post-reset err", 64'(dest_error), 64'(0));
        chk("post-reset iter", 64'(iteration_count), 64'(0));
        chk("post-reset nextIteration", 64'(nextIteration), 64'(0));
        req_valid = '0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #1;
        chk("restart clear", 64'(nextIteration), 64'(1));
        chk("restart iter", 64'(iteration_count), 64'(0));
        @(negedge clock);
        req_valid = 4'b1111;
        #1;
        chk("restart first grant", 64'(req_ready), 64'(4'b0010));
        @(negedge clock);
        req_valid = '0;
        thread_scatter_done = 4'b1111;
        @(negedge clock);
        thread_scatter_done = '0;
        for (int k = 0; k < 8 && !scatter_operation_complete; k++) @(negedge clock);
        chk("restart reaches finish", 64'(scatter_operation_complete), 64'(1));
        gather_operation_complete = 1'b1;
        @(negedge clock);
        gather_operation_complete = 1'b0;
        #1;
        chk("restart advance", 64'(scatter_operation_complete), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
